load_store_unit: RTL and testbench

- Multi-cycle load/store sequencer between the core's memory-stage signals and data_memory (word-indexed, one word-wide write port, asynchronous read).
- Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Flags misaligned, illegal-funct3 and out-of-range requests.

---
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer: turns byte-addressed RV32I memory requests into word
// accesses on a single-port, asynchronous-read data memory. Sub-word stores
// are done as read-modify-write; loads are sign- or zero-extended.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 65536
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  localparam logic [33:0] AddrLimit = 34'(MEM_WORDS) << 2;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [1:0] {StIdle, StAccess, StRmwWrite, StResp} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        req_err;
  logic        word_store;
  logic [4:0]  lane_shift;
  logic [31:0] rd_lane;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [31:0] load_data;

  // Classify the incoming request; evaluated on the raw inputs, used only at accept.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      Funct3B:  req_err = 1'b0;
      Funct3H:  req_err = req_addr[0];
      Funct3W:  req_err = |req_addr[1:0];
      Funct3Bu: req_err = req_we;
      Funct3Hu: req_err = req_we | req_addr[0];
      default:  req_err = 1'b1;
    endcase
    if ({2'b00, req_addr} >= AddrLimit) req_err = 1'b1;
  end

  assign word_store = we_q && (funct3_q == Funct3W);
  assign lane_shift = {addr_q[1:0], 3'b000};
  assign rd_lane    = mem_RD >> lane_shift;
  assign lane_mask  = (funct3_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << lane_shift;
  assign merged     = (mem_RD & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

  // Select and extend the addressed byte/half of the read word.
  always_comb begin
    load_data = 32'h0;
    case (funct3_q)
      Funct3B:  load_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
      Funct3H:  load_data = {{16{rd_lane[15]}}, rd_lane[15:0]};
      Funct3W:  load_data = mem_RD;
      Funct3Bu: load_data = {24'h0, rd_lane[7:0]};
      Funct3Hu: load_data = {16'h0, rd_lane[15:0]};
      default:  load_data = 32'h0;
    endcase
  end

  // Memory-side drive; rst gating keeps a reset edge from ever committing a write.
  always_comb begin
    mem_WD = 32'h0;
    if (state_q == StRmwWrite) begin
      mem_WD = merged_q;
    end else if (state_q == StAccess && word_store) begin
      mem_WD = wdata_q;
    end
  end

  assign mem_WE = rst && ((state_q == StAccess && word_store) || state_q == StRmwWrite);
  assign mem_A  = {2'b00, addr_q[31:2]};

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  // Transaction sequencer with registered response outputs.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      merged_q     <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q         <= req_we;
            funct3_q     <= req_funct3;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= req_err;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          // Only legal stores get here, so any non-word store is SB or SH.
          if (we_q && !word_store) begin
            merged_q <= merged;
            state_q  <= StRmwWrite;
          end else begin
            if (!we_q) resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StRmwWrite: begin
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic against a byte-level reference memory model.
module tb_load_store_unit;

  localparam int unsigned MemWords = 65536;

  logic        CLK = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [31:0] mem     [0:MemWords-1];
  logic [31:0] ref_mem [0:MemWords-1];
  logic        tb_we = 1'b0;
  logic [15:0] tb_waddr = 16'h0;
  logic [31:0] tb_wdata = 32'h0;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  // Attached data memory: asynchronous read, one write port (bench preload when DUT idle).
  assign mem_RD = mem[mem_A[15:0]];
  always @(posedge CLK) begin
    if (mem_WE) mem[mem_A[15:0]] <= mem_WD;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  load_store_unit #(.MEM_WORDS(MemWords)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  task automatic preload(input logic [15:0] idx, input logic [31:0] val);
    @(negedge CLK);
    tb_we = 1'b1; tb_waddr = idx; tb_wdata = val; ref_mem[idx] = val;
    @(negedge CLK);
    tb_we = 1'b0;
  endtask

  // Reference model: byte-addressed memory semantics of RV32I loads/stores.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic err,
                                output logic [31:0] rd);
    int unsigned size;
    int unsigned a;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    err = 1'b0;
    if (size == 0) err = 1'b1;
    else if (addr % size != 0) err = 1'b1;
    if (we && f3[2]) err = 1'b1;
    if (64'(addr) >= 64'(MemWords) * 64'd4) err = 1'b1;
    rd = 32'h0;
    if (!err) begin
      for (int unsigned i = 0; i < size; i++) begin
        a = addr + i;
        if (we) ref_mem[a >> 2][8*(a % 4) +: 8] = wd[8*i +: 8];
        else    rd[8*i +: 8] = ref_mem[a >> 2][8*(a % 4) +: 8];
      end
      if (!we && size < 4 && !f3[2] && rd[8*size-1]) rd = rd | (32'hffff_ffff << (8*size));
    end
  endfunction

  // Issue one request and observe five cycles after the accept edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output int pulses,
                        output int we_cnt, output logic [31:0] wd_seen,
                        output logic [31:0] a_seen, output logic [31:0] rdata,
                        output logic err, output logic [31:0] rdata_late);
    int waitc;
    waitc = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    while (!req_ready && waitc < 20) begin
      @(negedge CLK);
      waitc++;
    end
    @(posedge CLK);
    lat = 0; pulses = 0; we_cnt = 0; wd_seen = 32'h0; a_seen = 32'h0;
    rdata = 32'h0; err = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        req_valid = 1'b0;
        a_seen = mem_A;
      end
      if (mem_WE) begin
        we_cnt++;
        wd_seen = mem_WD;
      end
      if (resp_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = k; rdata = resp_rdata; err = resp_err;
        end
      end
    end
    rdata_late = resp_rdata;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h8000; req_wdata = 32'h5555_5555;
    repeat (2) @(negedge CLK);
    checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL reset_we_low got=%b exp=0", mem_WE); end
    req_valid = 1'b0; rst = 1'b1;
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_WE); end
    checks++; if (mem_A !== 32'h0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_A); end
    checks++; if (mem_WD !== 32'h0) begin errors++; $display("FAIL reset_mem_wd got=%h exp=0", mem_WD); end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_we;
    logic [31:0] exp_wd;
  } dir_t;

  task automatic test_directed;
    dir_t d [10];
    int lat, pulses, we_cnt;
    logic [31:0] wd_seen, a_seen, rdata, rdata_late;
    logic err;
    d[0] = '{1'b0, 3'b010, 32'h8000, 32'h0,         32'h0000_000a, 2, 0, 32'h0};
    d[1] = '{1'b1, 3'b000, 32'h8001, 32'h1234_56ab, 32'h0,         3, 1, 32'h0000_ab0a};
    d[2] = '{1'b0, 3'b000, 32'h8001, 32'h0,         32'hffff_ffab, 2, 0, 32'h0};
    d[3] = '{1'b0, 3'b100, 32'h8001, 32'h0,         32'h0000_00ab, 2, 0, 32'h0};
    d[4] = '{1'b0, 3'b010, 32'h8000, 32'h0,         32'h0000_ab0a, 2, 0, 32'h0};
    d[5] = '{1'b1, 3'b001, 32'h8002, 32'h0000_ffee, 32'h0,         3, 1, 32'hffee_ab0a};
    d[6] = '{1'b0, 3'b001, 32'h8002, 32'h0,         32'hffff_ffee, 2, 0, 32'h0};
    d[7] = '{1'b0, 3'b101, 32'h8002, 32'h0,         32'h0000_ffee, 2, 0, 32'h0};
    d[8] = '{1'b1, 3'b010, 32'h8004, 32'hdead_beef, 32'h0,         2, 1, 32'hdead_beef};
    d[9] = '{1'b0, 3'b010, 32'h8004, 32'h0,         32'hdead_beef, 2, 0, 32'h0};
    preload(16'h2000, 32'h0000_000a);
    preload(16'h2001, 32'h0);
    for (int i = 0; i < 10; i++) begin
      do_req(d[i].we, d[i].f3, d[i].addr, d[i].wd, lat, pulses, we_cnt, wd_seen, a_seen,
             rdata, err, rdata_late);
      checks++; if (lat != d[i].exp_lat) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, d[i].exp_lat); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL dir%0d_pulses got=%0d exp=1", i, pulses); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL dir%0d_err got=%b exp=0", i, err); end
      checks++; if (rdata !== d[i].exp_rd) begin errors++; $display("FAIL dir%0d_rdata got=%h exp=%h", i, rdata, d[i].exp_rd); end
      checks++; if (rdata_late !== d[i].exp_rd) begin errors++; $display("FAIL dir%0d_rdata_hold got=%h exp=%h", i, rdata_late, d[i].exp_rd); end
      checks++; if (we_cnt != d[i].exp_we) begin errors++; $display("FAIL dir%0d_we_count got=%0d exp=%0d", i, we_cnt, d[i].exp_we); end
      checks++; if (a_seen !== (d[i].addr >> 2)) begin errors++; $display("FAIL dir%0d_mem_a got=%h exp=%h", i, a_seen, d[i].addr >> 2); end
      if (d[i].exp_we != 0) begin
        checks++; if (wd_seen !== d[i].exp_wd) begin errors++; $display("FAIL dir%0d_mem_wd got=%h exp=%h", i, wd_seen, d[i].exp_wd); end
      end
    end
  endtask

  task automatic test_errors;
    logic        ew  [8];
    logic [2:0]  ef3 [8];
    logic [31:0] ea  [8];
    logic [31:0] s0, s1;
    int lat, pulses, we_cnt;
    logic [31:0] wd_seen, a_seen, rdata, rdata_late;
    logic err;
    ew[0] = 1'b1; ef3[0] = 3'b001; ea[0] = 32'h8003;
    ew[1] = 1'b0; ef3[1] = 3'b010; ea[1] = 32'h8002;
    ew[2] = 1'b0; ef3[2] = 3'b011; ea[2] = 32'h8000;
    ew[3] = 1'b1; ef3[3] = 3'b100; ea[3] = 32'h8000;
    ew[4] = 1'b0; ef3[4] = 3'b010; ea[4] = 32'h0004_0000;
    ew[5] = 1'b1; ef3[5] = 3'b010; ea[5] = 32'h0004_0000;
    ew[6] = 1'b1; ef3[6] = 3'b111; ea[6] = 32'h8000;
    ew[7] = 1'b1; ef3[7] = 3'b101; ea[7] = 32'h8002;
    s0 = mem[16'h2000];
    s1 = mem[16'h2001];
    for (int i = 0; i < 8; i++) begin
      do_req(ew[i], ef3[i], ea[i], 32'hffff_ffff, lat, pulses, we_cnt, wd_seen, a_seen,
             rdata, err, rdata_late);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err%0d_flag got=%b exp=1", i, err); end
      checks++; if (lat != 1) begin errors++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got=%h exp=0", i, rdata); end
      checks++; if (we_cnt != 0) begin errors++; $display("FAIL err%0d_we_count got=%0d exp=0", i, we_cnt); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL err%0d_pulses got=%0d exp=1", i, pulses); end
    end
    checks++; if (mem[16'h2000] !== s0 || mem[16'h2001] !== s1) begin errors++; $display("FAIL err_mem_unchanged got=%h_%h exp=%h_%h", mem[16'h2000], mem[16'h2001], s0, s1); end
  endtask

  // Reset during ACCESS (v=0) or on the RMW_WRITE edge (v=1) of an SB.
  task automatic test_reset_mid;
    int lat, pulses, we_cnt, late_resp;
    logic [31:0] wd_seen, a_seen, rdata, rdata_late;
    logic err;
    for (int v = 0; v < 2; v++) begin
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h8000;
      req_wdata = 32'h0000_00ff;
      @(posedge CLK);
      @(negedge CLK);
      req_valid = 1'b0;
      if (v == 1) @(negedge CLK);
      rst = 1'b0;
      #1;
      checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL rmid%0d_we got=%b exp=0", v, mem_WE); end
      @(negedge CLK);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid%0d_ready got=%b exp=1", v, req_ready); end
      rst = 1'b1;
      late_resp = 0;
      repeat (4) begin
        @(negedge CLK);
        if (resp_valid) late_resp++;
      end
      checks++; if (late_resp != 0) begin errors++; $display("FAIL rmid%0d_no_resp got=%0d exp=0", v, late_resp); end
      checks++; if (mem[16'h2000] !== 32'hffee_ab0a) begin errors++; $display("FAIL rmid%0d_mem got=%h exp=ffeeab0a", v, mem[16'h2000]); end
      do_req(1'b0, 3'b010, 32'h8000, 32'h0, lat, pulses, we_cnt, wd_seen, a_seen, rdata, err,
             rdata_late);
      checks++; if (rdata !== 32'hffee_ab0a || lat != 2) begin errors++; $display("FAIL rmid%0d_reload got=%h lat=%0d exp=ffeeab0a lat=2", v, rdata, lat); end
    end
  endtask

  // Hold req_valid across a transaction with a changing address.
  task automatic test_back_to_back;
    int pulses;
    logic [31:0] vals [4];
    pulses = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000;
    req_wdata = 32'h0;
    @(posedge CLK);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (k == 1) req_addr = 32'h8004;
      if (k == 4) req_valid = 1'b0;
      if (k == 1 || k == 2) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready_k%0d got=%b exp=0", k, req_ready); end
      end
      if (resp_valid) begin
        if (pulses < 4) vals[pulses] = resp_rdata;
        pulses++;
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL busy_pulses got=%0d exp=2", pulses); end
    if (pulses >= 2) begin
      checks++; if (vals[0] !== 32'hffee_ab0a) begin errors++; $display("FAIL busy_first got=%h exp=ffeeab0a", vals[0]); end
      checks++; if (vals[1] !== 32'hdead_beef) begin errors++; $display("FAIL busy_second got=%h exp=deadbeef", vals[1]); end
    end
  endtask

  task automatic test_random;
    logic        we, err, exp_err;
    logic [2:0]  f3;
    logic [31:0] addr, wd, exp_rd, wd_seen, a_seen, rdata, rdata_late;
    int lat, pulses, we_cnt, exp_lat, sel;
    for (int i = 0; i < 8; i++) preload(16'h2000 + 16'(i), $urandom);
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0) addr = 32'h0004_0000 + $urandom_range(0, 15);
      else if (sel == 1) addr = $urandom | 32'h8000_0000;
      else addr = 32'h8000 + $urandom_range(0, 31);
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      model(we, f3, addr, wd, exp_err, exp_rd);
      exp_lat = exp_err ? 1 : ((we && f3 != 3'b010) ? 3 : 2);
      do_req(we, f3, addr, wd, lat, pulses, we_cnt, wd_seen, a_seen, rdata, err, rdata_late);
      checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd%0d_err got=%b exp=%b", n, err, exp_err); end
      checks++; if (rdata !== exp_rd || rdata_late !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata got=%h/%h exp=%h", n, rdata, rdata_late, exp_rd); end
      checks++; if (lat != exp_lat || pulses != 1) begin errors++; $display("FAIL rnd%0d_timing got=%0d/%0d exp=%0d/1", n, lat, pulses, exp_lat); end
      checks++; if (we_cnt != ((we && !exp_err) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_we_count got=%0d", n, we_cnt); end
      if (we && !exp_err) begin
        checks++; if (wd_seen !== ref_mem[addr[17:2]]) begin errors++; $display("FAIL rnd%0d_mem_wd got=%h exp=%h", n, wd_seen, ref_mem[addr[17:2]]); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem[16'h2000 + 16'(i)] !== ref_mem[16'h2000 + 16'(i)]) begin errors++; $display("FAIL rnd_mem%0d got=%h exp=%h", i, mem[16'h2000 + 16'(i)], ref_mem[16'h2000 + 16'(i)]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
